// File: rtl/fifo_stream_reader.sv
`timescale 1ns/1ps
// fifo_stream_reader: drains a synchronous FIFO read port into a
// valid/ready stream with PKT_LEN framing via a 3-entry skid buffer.
module fifo_stream_reader #(
    parameter int PKT_LEN = 8,
    parameter int DATA_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd_en,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic [15:0]       pkt_count,
    output logic              busy
);
    localparam logic [15:0] LAST_BEAT = 16'(PKT_LEN - 1);

    logic [1:0]        occ_q, occ_d;
    logic [1:0]        head_q, head_d;
    logic [1:0]        tail_q, tail_d;
    logic              pend_q;
    logic [15:0]       beat_q, beat_d;
    logic [15:0]       pkt_q, pkt_d;
    logic [DATA_W-1:0] mem_q [3];
    logic              xfer;
    logic              at_last;

    function automatic logic [1:0] wrap_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Reserve a slot for every read in flight so the buffer never overflows.
    assign fifo_rd_en = enable & ~fifo_empty
                      & (({1'b0, occ_q} + {2'b0, pend_q}) < 3'd3);
    assign m_valid    = (occ_q != 2'd0);
    assign m_data     = mem_q[head_q];
    assign at_last    = (beat_q == LAST_BEAT);
    assign m_last     = m_valid & at_last;
    assign xfer       = m_valid & m_ready;
    assign busy       = m_valid | pend_q;
    assign pkt_count  = pkt_q;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        beat_d = beat_q;
        pkt_d  = pkt_q;
        occ_d  = occ_q + {1'b0, pend_q} - {1'b0, xfer};
        if (pend_q) begin
            tail_d = wrap_inc(tail_q);
        end
        if (xfer) begin
            head_d = wrap_inc(head_q);
            if (at_last) begin
                beat_d = 16'd0;
                pkt_d  = pkt_q + 16'd1;
            end else begin
                beat_d = beat_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q  <= 2'd0;
            head_q <= 2'd0;
            tail_q <= 2'd0;
            pend_q <= 1'b0;
            beat_q <= 16'd0;
            pkt_q  <= 16'd0;
            for (int i = 0; i < 3; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
            tail_q <= tail_d;
            pend_q <= fifo_rd_en;
            beat_q <= beat_d;
            pkt_q  <= pkt_d;
            if (pend_q) begin
                mem_q[tail_q] <= fifo_data;
            end
        end
    end
endmodule

// File: tb/tb_fifo_stream_reader.sv
`timescale 1ns/1ps
// tb_fifo_stream_reader: two readers (PKT_LEN 8 and 5) fed by FIFO models,
// checked against a word log and transfer-count packet model.
module tb_fifo_stream_reader;
    logic        clk;
    logic        rst_n;
    logic        en   [2];
    logic        rdy  [2];
    logic        emp  [2];
    logic [15:0] fd   [2];
    logic        rd   [2];
    logic [15:0] md   [2];
    logic        val  [2];
    logic        last [2];
    logic [15:0] pc   [2];
    logic        bsy  [2];
    logic        wr   [2];
    logic [15:0] wd   [2];

    fifo_stream_reader #(.PKT_LEN(8), .DATA_W(16)) u0 (
        .clk(clk), .rst_n(rst_n), .enable(en[0]),
        .fifo_empty(emp[0]), .fifo_data(fd[0]), .fifo_rd_en(rd[0]),
        .m_data(md[0]), .m_valid(val[0]), .m_ready(rdy[0]),
        .m_last(last[0]), .pkt_count(pc[0]), .busy(bsy[0])
    );

    fifo_stream_reader #(.PKT_LEN(5), .DATA_W(16)) u1 (
        .clk(clk), .rst_n(rst_n), .enable(en[1]),
        .fifo_empty(emp[1]), .fifo_data(fd[1]), .fifo_rd_en(rd[1]),
        .m_data(md[1]), .m_valid(val[1]), .m_ready(rdy[1]),
        .m_last(last[1]), .pkt_count(pc[1]), .busy(bsy[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // 64-deep FIFO model with registered output; every write is logged.
    logic [15:0] fm   [2][64];
    logic [15:0] wlog [2][1024];
    int fh [2];
    int ft [2];
    int fn [2];
    int wi [2] = '{0, 0};

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                fh[k]  <= 0;
                ft[k]  <= 0;
                fn[k]  <= 0;
                fd[k]  <= 16'h0;
                emp[k] <= 1'b1;
            end else begin
                if (rd[k] && fn[k] != 0) begin
                    fd[k] <= fm[k][fh[k]];
                    fh[k] <= (fh[k] + 1) % 64;
                end
                if (wr[k]) begin
                    fm[k][ft[k]]          <= wd[k];
                    ft[k]                 <= (ft[k] + 1) % 64;
                    wlog[k][wi[k] % 1024] <= wd[k];
                    wi[k]                 <= wi[k] + 1;
                end
                fn[k]  <= fn[k] + int'(wr[k])
                        - int'(rd[k] && fn[k] != 0);
                emp[k] <= (fn[k] + int'(wr[k])
                        - int'(rd[k] && fn[k] != 0)) == 0;
            end
        end
    end

    typedef struct {
        int nw;
        int stall;
        int exp_rd;
        int exp_pkt;
    } vec_t;

    vec_t tbl [4];
    int tests = 0;
    int fails = 0;
    int nrd  [2];
    int nout [2];
    int ri   [2];
    logic        stl [2];
    logic [15:0] sd  [2];

    function automatic int plen(input int k);
        return (k == 0) ? 8 : 5;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic tick();
        int ost;
        #1;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                chk("rst_rd_en", rd[k], 0);
                chk("rst_valid", val[k], 0);
                chk("rst_last", last[k], 0);
                chk("rst_data", md[k], 0);
                chk("rst_pkt", pc[k], 0);
                chk("rst_busy", bsy[k], 0);
                nrd[k]  = 0;
                nout[k] = 0;
                ri[k]   = wi[k];
                stl[k]  = 1'b0;
            end else begin
                ost = nrd[k] - nout[k];
                chk("busy", bsy[k], ost != 0);
                chk("pkt_count", pc[k], (nout[k] / plen(k)) % 65536);
                chk("m_last", last[k],
                    val[k] && (nout[k] % plen(k) == plen(k) - 1));
                if (val[k]) chk("valid_src", ost > 0, 1);
                if (rd[k]) begin
                    chk("rd_room", ost < 3, 1);
                    chk("rd_nonempty", emp[k], 0);
                end
                if (stl[k]) begin
                    chk("stall_valid", val[k], 1);
                    chk("stall_data", md[k], sd[k]);
                end
                if (val[k] && rdy[k]) begin
                    chk("no_dup", ri[k] < wi[k], 1);
                    chk("m_data", md[k], wlog[k][ri[k] % 1024]);
                    ri[k]++;
                    nout[k]++;
                end
                if (rd[k]) nrd[k]++;
                stl[k] = val[k] && !rdy[k];
                sd[k]  = md[k];
            end
        end
        @(negedge clk);
        #2;
    endtask

    task automatic write(input int k, input logic [15:0] w);
        wr[k] = 1'b1;
        wd[k] = w;
        tick();
        wr[k] = 1'b0;
    endtask

    task automatic drain(input int k, input int bound, output int cyc);
        cyc = 0;
        while (bsy[k] || !emp[k]) begin
            if (cyc >= bound) begin
                chk("drain_timeout", 1, 0);
                break;
            end
            tick();
            cyc++;
        end
    endtask

    initial begin
        int c;
        int n0;
        int d0;
        int nw;
        tbl[0] = '{16, 0, 0, 2};
        tbl[1] = '{10, 20, 3, 3};
        tbl[2] = '{2, 5, 2, 3};
        tbl[3] = '{4, 6, 3, 4};
        for (int k = 0; k < 2; k++) begin
            en[k]  = 1'b0;
            rdy[k] = 1'b0;
            wr[k]  = 1'b0;
            wd[k]  = 16'h0;
            stl[k] = 1'b0;
        end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        tick();
        rst_n = 1'b1;
        tick();

        for (int r = 0; r < 4; r++) begin
            en[0]  = 1'b0;
            rdy[0] = 1'b0;
            for (int i = 0; i < tbl[r].nw; i++) begin
                write(0, (r == 0) ? 16'(i) : 16'($urandom));
            end
            en[0] = 1'b1;
            if (tbl[r].stall == 0) begin
                rdy[0] = 1'b1;
                drain(0, 200, c);
                chk("full_rate_cycles", c, tbl[r].nw + 2);
            end else begin
                n0 = nrd[0];
                repeat (tbl[r].stall) tick();
                chk("stall_reads", nrd[0] - n0, tbl[r].exp_rd);
                chk("stall_head", md[0], wlog[0][ri[0] % 1024]);
                rdy[0] = 1'b1;
                drain(0, 200, c);
            end
            chk("row_pkt", pc[0], tbl[r].exp_pkt);
            chk("row_delivered", ri[0], wi[0]);
        end

        en[0]  = 1'b1;
        rdy[0] = 1'b1;
        write(0, 16'hA5A5);
        chk("single_rd", rd[0], 1);
        tick();
        chk("single_rd_once", rd[0], 0);
        chk("single_early", val[0], 0);
        tick();
        chk("single_valid", val[0], 1);
        chk("single_data", md[0], 16'hA5A5);
        chk("single_last", last[0], 0);
        tick();
        chk("single_idle", bsy[0], 0);

        en[0] = 1'b0;
        for (int i = 0; i < 7; i++) write(0, 16'($urandom));
        en[0] = 1'b1;
        n0 = nrd[0];
        d0 = nout[0];
        tick();
        en[0] = 1'b0;
        repeat (10) tick();
        chk("gate_reads", nrd[0] - n0, 1);
        chk("gate_pending", nout[0] - d0, 1);
        en[0] = 1'b1;
        drain(0, 100, c);
        chk("gate_pkt", pc[0], 5);
        chk("gate_words", nout[0] - d0, 7);

        en[0]  = 1'b0;
        rdy[0] = 1'b0;
        for (int i = 0; i < 5; i++) write(0, 16'($urandom));
        en[0] = 1'b1;
        repeat (3) tick();
        chk("pre_rst_busy", bsy[0], 1);
        rst_n = 1'b0;
        #1;
        chk("async_rd_en", rd[0], 0);
        chk("async_valid", val[0], 0);
        chk("async_last", last[0], 0);
        chk("async_data", md[0], 0);
        chk("async_pkt", pc[0], 0);
        chk("async_busy", bsy[0], 0);
        tick();
        tick();
        rst_n = 1'b1;
        rdy[0] = 1'b1;
        repeat (5) begin
            chk("post_rst_valid", val[0], 0);
            tick();
        end
        write(0, 16'h1234);
        drain(0, 50, c);
        chk("post_rst_words", nout[0], 1);

        en[1] = 1'b1;
        nw = 0;
        for (int i = 0; i < 6000; i++) begin
            if (nw == 200 && !bsy[1] && emp[1]) break;
            rdy[1] = 1'($urandom_range(0, 1));
            if (nw < 200 && fn[1] < 60 && $urandom_range(0, 1) == 1) begin
                wr[1] = 1'b1;
                wd[1] = 16'($urandom);
                nw++;
            end else begin
                wr[1] = 1'b0;
            end
            tick();
        end
        wr[1]  = 1'b0;
        rdy[1] = 1'b1;
        drain(1, 100, c);
        chk("rand_words", nout[1], 200);
        chk("rand_pkt", pc[1], 40);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
